// File: rtl/bus_arbiter_if.sv
// Device-side bus bundle of the round-robin packet arbiter.
// The master modport is the arbiter's view; slave is the device/FIFO side.
interface bus_arbiter_if #(
  parameter int unsigned drvrs   = 4,
  parameter int unsigned pckg_sz = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that moves one packet per 3-cycle slot (IDLE/POP/PUSH)
// from a device FIFO head to one device, all devices but the sender, or nowhere.
module bus_arbiter #(
  parameter int unsigned bits      = 1,
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_if.master     bus,
  output logic              busy,
  output logic [3:0]        grant_id,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned IDW    = 4;
  localparam int unsigned DSTW   = 8;
  localparam int unsigned MAXDEV = 16;
  localparam logic [IDW:0]       NDRV      = (IDW+1)'(drvrs);
  localparam logic [IDW-1:0]     LAST_INIT = IDW'(drvrs - 1);
  localparam logic [drvrs-1:0]   ALL_DEV   = '1;

  if (bits != 1) begin : g_bits_chk
    $error("bus_arbiter supports only bits=1");
  end

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;

  // Zero-extend to 16 devices so a 4-bit device index always selects exactly.
  logic [MAXDEV-1:0]  pend16;
  logic [pckg_sz-1:0] heads [MAXDEV];

  assign pend16 = MAXDEV'(bus.pndng);

  for (genvar i = 0; i < MAXDEV; i++) begin : g_head
    if (i < drvrs) begin : g_dev
      assign heads[i] = bus.D_pop[i*pckg_sz +: pckg_sz];
    end else begin : g_pad
      assign heads[i] = '0;
    end
  end

  // Round-robin search starting one past the last device actually served.
  logic [IDW-1:0] start_idx;
  logic [IDW:0]   cand;
  logic [IDW-1:0] arb_idx;
  logic           arb_found;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    start_idx = (last_grant == LAST_INIT) ? '0 : last_grant + 1'b1;
    for (int k = 0; k < int'(drvrs); k++) begin
      cand = {1'b0, start_idx} + (IDW+1)'(k);
      if (cand >= NDRV) cand = cand - NDRV;
      if (!arb_found && pend16[cand[IDW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDW-1:0];
      end
    end
  end

  // Destination decode of the granted head packet.
  logic [pckg_sz-1:0] head_pkt;
  logic [DSTW-1:0]    dest;
  logic [drvrs-1:0]   grant_oh;
  logic [drvrs-1:0]   dest_oh;
  logic [drvrs-1:0]   push_mask;

  always_comb begin
    head_pkt = heads[grant_id];
    dest     = head_pkt[pckg_sz-1 -: DSTW];
    grant_oh = drvrs'(1) << grant_id;
    dest_oh  = drvrs'(1) << dest[IDW-1:0];
    if (dest == broadcast)
      push_mask = ALL_DEV & ~grant_oh;
    else if (dest < DSTW'(drvrs) && dest[IDW-1:0] != grant_id)
      push_mask = dest_oh;
    else
      push_mask = '0;
  end

  // pop follows the live request so a head withdrawn during POP is never dequeued.
  always_comb begin
    bus.pop = '0;
    if (state == POP && pend16[grant_id]) bus.pop = grant_oh;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bus.push   <= '0;
      bus.D_push <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      last_grant <= LAST_INIT;
    end else begin
      bus.push <= '0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant_id <= arb_idx;
            state    <= POP;
            busy     <= 1'b1;
          end
        end
        POP: begin
          if (pend16[grant_id]) begin
            bus.D_push <= head_pkt;
            bus.push   <= push_mask;
            last_grant <= grant_id;
            state      <= PUSH;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        PUSH: begin
          // A broadcast is one delivered packet regardless of fan-out.
          if (|bus.push) begin
            if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
          end else begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter bits, default 1: bus count; this block SHALL support only bits=1.
REQ-002 Parameter drvrs, default 4: number of devices, 2..16.
REQ-003 Parameter pckg_sz, default 16: packet width, minimum 9.
REQ-004 Parameter broadcast, default 8'hFF: destination ID that addresses all devices.
REQ-005 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-006 Port reset  input  1: asynchronous, active-high reset.
REQ-007 Port pndng  input  drvrs: bit i high means device i's transmit FIFO holds a packet at its head.
REQ-008 Port D_pop  input  drvrs*pckg_sz: head packet of device i in bits [i*pckg_sz +: pckg_sz].
REQ-009 Port pop  output  drvrs: one-cycle pulse that dequeues device i's head packet.
REQ-010 Port push  output  drvrs: one-cycle pulse that enqueues D_push into device i.
REQ-011 Port D_push  output  pckg_sz: packet driven to all devices, valid while any push bit is high.
REQ-012 Port busy  output  1: high whenever the FSM is not in IDLE.
REQ-013 Port grant_id  output  4: index of the currently or last granted device.
REQ-014 Port pkt_cnt  output  16: count of delivered packets, saturating at 16'hFFFF.
REQ-015 Port drop_cnt  output  16: count of dropped packets, saturating at 16'hFFFF.

Function
REQ-016 Destination ID SHALL be D_pop packet bits [pckg_sz-1 -: 8].
REQ-017 The FSM SHALL have exactly three states: IDLE, POP and PUSH.
REQ-018 IDLE, any pndng high: select the first set pndng bit searching from (last_grant+1) mod drvrs upward with wrap-around; register it in grant_id; go to POP.
REQ-019 IDLE, pndng all zero: remain in IDLE with all pop and push bits low.
REQ-020 POP, pndng[grant_id] still high: assert pop[grant_id] for that cycle only; latch the granted D_pop slice into a packet register; update last_grant to grant_id; go to PUSH.
REQ-021 POP, pndng[grant_id] low: no pop, no counter change, last_grant unchanged; return to IDLE.
REQ-022 PUSH, destination < drvrs and not equal to grant_id: assert push[destination] only.
REQ-023 PUSH, destination == broadcast: assert push on every device except grant_id.
REQ-024 PUSH, destination == grant_id, or destination >= drvrs and not broadcast: assert no push bit (drop).
REQ-025 In every PUSH cycle, D_push SHALL equal the latched packet.
REQ-026 In PUSH, pkt_cnt SHALL increment once per delivered packet (a broadcast counts once); drop_cnt SHALL increment on a drop.
REQ-027 PUSH SHALL always return to IDLE, giving a fixed 3-cycle slot per packet.
REQ-028 Latency from pndng rising in IDLE: pop asserts in cycle +1 and push in cycle +2.
REQ-029 No two bits of pop SHALL be high in the same cycle.
REQ-030 pop and push SHALL never be high in the same cycle.
REQ-031 D_push SHALL hold its last value outside PUSH.

Reset
REQ-032 When reset is asserted, the block SHALL immediately apply: state=IDLE, pop=0, push=0, D_push=0, busy=0, grant_id=0, pkt_cnt=0, drop_cnt=0, last_grant=drvrs-1.
REQ-033 Reset asserted during POP or PUSH SHALL abort the transfer with no further pop or push, even if a packet was already popped.
REQ-034 After reset deasserts, the first arbitration SHALL start its search at device 0.

Verification (drvrs=4, pckg_sz=16, broadcast=8'hFF)
REQ-035 Unicast: pndng=4'b0010, D_pop slice1=16'h0312 -> pop=4'b0010 at +1; push=4'b1000, D_push=16'h0312 at +2; pkt_cnt=1.
REQ-036 Round-robin: pndng=4'b1111 held for 12 cycles -> grants in order 0,1,2,3; exactly one pop every 3 cycles.
REQ-037 Broadcast: device 2 sends 16'hFFAB -> push=4'b1011 for one cycle, D_push=16'hFFAB, pkt_cnt +1.
REQ-038 Drops: device 0 sends 16'h0000 (self), then 16'h07CD (ID 7 >= drvrs) -> no push either time; pop pulses twice; drop_cnt=2.
REQ-039 Reset mid-transfer: assert reset in the PUSH cycle -> push=0 that cycle; counters=0; next grant goes to device 0.
REQ-040 Vanishing request: pndng[1] drops in the POP cycle -> no pop, return to IDLE, counters unchanged.
